// File: rtl/blaster_pkg.sv
// Shared types for the current-profile sequencer: FSM state encoding and the
// profile segment record stored in the segment table.
package blaster_pkg;

  localparam int SEG_DUR_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0]           iset;
    logic [SEG_DUR_W-1:0] dur;
  } seg_t;

  // Terminal strobe count of a segment; a zero duration still lasts one strobe.
  function automatic logic [SEG_DUR_W-1:0] last_count(input logic [SEG_DUR_W-1:0] dur);
    if (dur == SEG_DUR_W'(0)) begin
      last_count = SEG_DUR_W'(0);
    end else begin
      last_count = dur - SEG_DUR_W'(1);
    end
  endfunction

endpackage

// File: rtl/profile_table.sv
// Segment table for the current-profile sequencer: NSEG-entry register file
// with a synchronous write port and a combinational read port.
module profile_table
  import blaster_pkg::*;
#(
  parameter int NSEG = 4,
  localparam int AW  = $clog2(NSEG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  seg_t          wr_data,
  input  logic [AW-1:0] rd_addr,
  output seg_t          rd_data
);

  seg_t mem_r [NSEG];

  // Table storage; cleared on reset so no stale profile survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSEG; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/current_profile_seq.sv
// Current-profile sequencer: steps the PWM current target through a table of
// {iset, duration} segments, timed in ADC strobes, with abort handling.
module current_profile_seq
  import blaster_pkg::*;
#(
  parameter int NSEG  = 4,
  parameter int DUR_W = 16,
  localparam int AW   = $clog2(NSEG),
  localparam int NW   = $clog2(NSEG) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ad_strobe,
  input  logic             start,
  input  logic             abort,
  input  logic [NW-1:0]    nseg,
  input  logic             seg_wr_en,
  input  logic [AW-1:0]    seg_wr_addr,
  input  logic [2:0]       seg_wr_iset,
  input  logic [DUR_W-1:0] seg_wr_dur,
  output logic [2:0]       iset,
  output logic             fire_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [AW-1:0]    seg_idx
);

  state_t           state_r;
  logic [DUR_W-1:0] cnt_r;
  logic [AW-1:0]    seg_idx_r;
  logic [NW-1:0]    nseg_r;
  logic             fire_en_r;
  logic             busy_r;
  logic             done_r;
  logic             aborted_r;

  seg_t             rd_seg_s;
  seg_t             wr_seg_s;
  logic             tbl_wr_en_s;
  logic             seg_end_s;
  logic             last_seg_s;
  logic [NW-1:0]    nseg_clamp_s;

  profile_table #(.NSEG(NSEG)) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tbl_wr_en_s),
    .wr_addr (seg_wr_addr),
    .wr_data (wr_seg_s),
    .rd_addr (seg_idx_r),
    .rd_data (rd_seg_s)
  );

  // Table write gating, segment-end detection and nseg range clamp.
  always_comb begin
    tbl_wr_en_s   = seg_wr_en && (state_r == S_IDLE);
    wr_seg_s.iset = seg_wr_iset;
    wr_seg_s.dur  = SEG_DUR_W'(seg_wr_dur);
    seg_end_s     = ad_strobe && (SEG_DUR_W'(cnt_r) == last_count(rd_seg_s.dur));
    last_seg_s    = ({1'b0, seg_idx_r} == (nseg_r - NW'(1)));
    if (nseg > NW'(NSEG)) begin
      nseg_clamp_s = NW'(NSEG);
    end else begin
      nseg_clamp_s = nseg;
    end
  end

  // Sequencer FSM with registered status outputs; abort outranks segment end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      seg_idx_r <= '0;
      nseg_r    <= '0;
      fire_en_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && !abort) begin
            cnt_r     <= '0;
            seg_idx_r <= '0;
            nseg_r    <= nseg_clamp_s;
            busy_r    <= 1'b1;
            if (nseg_clamp_s != NW'(0)) begin
              state_r   <= S_RUN;
              fire_en_r <= 1'b1;
            end else begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            state_r   <= S_ABORT;
            fire_en_r <= 1'b0;
            aborted_r <= 1'b1;
          end else if (seg_end_s) begin
            cnt_r <= '0;
            if (last_seg_s) begin
              state_r   <= S_DONE;
              fire_en_r <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              seg_idx_r <= seg_idx_r + AW'(1);
            end
          end else if (ad_strobe) begin
            cnt_r <= cnt_r + DUR_W'(1);
          end
        end
        S_DONE: begin
          done_r <= 1'b0;
          if (abort) begin
            state_r   <= S_ABORT;
            aborted_r <= 1'b1;
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end
        S_ABORT: begin
          if (!abort) begin
            state_r   <= S_IDLE;
            aborted_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          cnt_r     <= '0;
          seg_idx_r <= '0;
          fire_en_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          aborted_r <= 1'b0;
        end
      endcase
    end
  end

  assign iset    = (state_r == S_RUN) ? rd_seg_s.iset : 3'd0;
  assign fire_en = fire_en_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign aborted = aborted_r;
  assign seg_idx = seg_idx_r;

endmodule
